cdb_arbiter: RTL
================

# cdb_arbiter

Common-data-bus arbiter for the Tomasulo core. It accepts completed results from three execution sources: add/sub unit (port 0), mul/div unit (port 1) and load unit (port 2). Each result is buffered in a small per-source FIFO. Each cycle, one buffered result is granted round-robin and broadcast on the single CDB that feeds the reservation stations, register bank and ROB. A flush input discards all in-flight results on branch mispredict.

## Interface
- DW, 16, result data width (matches regbank/ROB entry width)
- TW, 3, ROB tag width (8-entry ROB)
- DEPTH, 2, entries per source FIFO (power of two not required, ≥1)
- clk1  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous discard of all buffered results and CDB output
- req_valid  in  3  per-source result valid (bit i = source i)
- req_tag  in  3*TW  per-source ROB tag, source i at [i*TW +: TW]
- req_data  in  3*DW  per-source result, source i at [i*DW +: DW]
- req_ready  out  3  per-source FIFO not full; transfer when valid&ready at posedge
- cdb_valid  out  1  registered broadcast valid
- cdb_tag  out  TW  registered broadcast ROB tag
- cdb_data  out  DW  registered broadcast data
- cdb_src  out  2  source index of current broadcast (0/1/2)
- grant  out  3  one-hot, combinational, source popped at next posedge

## Operation
- Per-source FIFO: DEPTH entries of {tag, data}, with count, rd/wr pointers wrapping at DEPTH. req_ready[i] = (count_i < DEPTH). It is combinational from count only, with no bypass, so a full FIFO refuses a push even in a cycle it pops.
- Push: req_valid[i] & req_ready[i] writes at wr_ptr_i and increments count_i. Simultaneous push and pop leaves count unchanged and both pointers advance.
- Arbitration: rr_ptr (0..2) marks the highest-priority source. Search order is rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3). The first source with count>0 wins. grant is one-hot for the winner, or 0 if all FIFOs are empty.
- On a grant to source i at a posedge:
  - pop head of FIFO i
  - cdb_valid←1, cdb_tag/cdb_data←head entry, cdb_src←i
  - rr_ptr←(i+1) mod 3
- With no grant: cdb_valid←0, rr_ptr unchanged. cdb_tag/data/src hold their previous values, which are don't-care when invalid.
- The CDB has no backpressure: consumers must absorb one broadcast per cycle.
- Flush (when rst=0):
  - all counts←0 and all pointers←0
  - cdb_valid←0, no grant that cycle, pushes that cycle dropped
  - rr_ptr keeps its value
- Reset overrides flush and everything else:
  - counts, pointers, rr_ptr←0
  - cdb_valid←0, cdb_tag←0, cdb_data←0, cdb_src←0
- Width rules: tag and data are passed bit-exact. No arithmetic is done on data. Pointer and count arithmetic is mod DEPTH and range 0..DEPTH respectively.

## Timing
- Reset values: cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0. req_ready=3'b111 in the cycle after the reset edge. grant=0.
- Latency: a result accepted at edge N is visible in the FIFO in cycle N. It earliest drives cdb_valid=1 after edge N+1, i.e. 1 cycle in the FIFO plus a registered output.
- Throughput: 1 broadcast per cycle aggregate. With all three sources continuously backlogged, each source gets exactly 1 grant per 3 cycles.
- Worst-case wait for a non-empty FIFO head is 2 cycles, which gives starvation freedom.
- req_ready deasserts in the cycle after the DEPTH-th accepted push without a pop. It reasserts in the cycle after the pop.
- Flush and reset take effect at the edge where they are sampled high. Outputs are clean (cdb_valid=0) in the following cycle. A flush asserted mid-burst loses all pending results, including any that would have been granted at that edge.

## Test plan
- Reset: hold rst 2 cycles with req_valid=3'b111.
  - Required: cdb_valid=0, tag/data/src=0, req_ready=3'b111 after release, no broadcast from requests offered during reset.
- Single source: push tag=5, data=16'h00A3 on port 1 at edge N.
  - Required: cdb_valid=1, cdb_tag=5, cdb_data=16'h00A3, cdb_src=1 after edge N+1, then cdb_valid=0.
- Simultaneous contention: all three sources push at edge N (tags 1, 2, 3), rr_ptr=0.
  - Required: broadcasts on consecutive cycles with src order 0, 1, 2 and tags 1, 2, 3.
  - Next contention round starts at the rr_ptr left by the last grant.
- Backpressure/full: port 2 holds valid for 4 cycles while ports 0 and 1 stay continuously backlogged.
  - Required: req_ready[2] drops after 2 accepted pushes. Port 2 gets exactly 1 grant per 3 cycles.
  - No entry is lost or duplicated and tags stay in FIFO order across pointer wrap-around.
- Flush mid-burst: load 2 entries in each FIFO, assert flush for one cycle after the first broadcast.
  - Required: cdb_valid=0 the cycle after the flush, and no further broadcasts until new pushes arrive.
  - The next push on port 0 broadcasts with 2-cycle latency.
- Flush with reset: assert rst and flush together with pending entries.
  - Required: full reset state, including rr_ptr=0, verified by the next 3-way contention granting port 0 first.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: three per-source result FIFOs
// drained round-robin onto one registered CDB broadcast.
module cdb_arbiter #(
    parameter int DW    = 16,
    parameter int TW    = 3,
    parameter int DEPTH = 2
) (
    input  logic            clk1,
    input  logic            rst,
    input  logic            flush,
    input  logic [2:0]      req_valid,
    input  logic [3*TW-1:0] req_tag,
    input  logic [3*DW-1:0] req_data,
    output logic [2:0]      req_ready,
    output logic            cdb_valid,
    output logic [TW-1:0]   cdb_tag,
    output logic [DW-1:0]   cdb_data,
    output logic [1:0]      cdb_src,
    output logic [2:0]      grant
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [TW-1:0] tag_q  [3][DEPTH];
    logic [DW-1:0] data_q [3][DEPTH];

    logic [PW-1:0] wr_q  [3];
    logic [PW-1:0] wr_d  [3];
    logic [PW-1:0] rd_q  [3];
    logic [PW-1:0] rd_d  [3];
    logic [CW-1:0] cnt_q [3];
    logic [CW-1:0] cnt_d [3];

    logic [1:0]    rr_q, rr_d;
    logic          vld_q, vld_d;
    logic [TW-1:0] tag_oq, tag_od;
    logic [DW-1:0] dat_oq, dat_od;
    logic [1:0]    src_q, src_d;

    logic [2:0]    push;
    logic [1:0]    win;
    logic          found;
    logic [2:0]    idx;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Ready depends on occupancy only; a full FIFO never bypasses.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            req_ready[i] = (cnt_q[i] < CW'(DEPTH));
        end
    end

    // Round-robin search starting at rr_q; suppressed by flush/reset.
    always_comb begin
        grant = '0;
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < 3; k++) begin
            idx = {1'b0, rr_q} + 3'(k);
            if (idx >= 3'd3) idx = idx - 3'd3;
            if (!found && cnt_q[idx[1:0]] != '0) begin
                found = 1'b1;
                win   = idx[1:0];
            end
        end
        if (found && !flush && !rst) grant[win] = 1'b1;
    end

    // Next-state for FIFO bookkeeping, rr pointer and CDB register.
    always_comb begin
        cnt_d  = cnt_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        push   = '0;
        rr_d   = rr_q;
        vld_d  = 1'b0;
        tag_od = tag_oq;
        dat_od = dat_oq;
        src_d  = src_q;
        for (int i = 0; i < 3; i++) begin
            push[i] = req_valid[i] & req_ready[i] & ~flush;
            if (push[i]) wr_d[i] = nxt(wr_q[i]);
            if (grant[i]) rd_d[i] = nxt(rd_q[i]);
            if (push[i] && !grant[i]) cnt_d[i] = cnt_q[i] + 1'b1;
            if (grant[i] && !push[i]) cnt_d[i] = cnt_q[i] - 1'b1;
            if (flush) begin
                cnt_d[i] = '0;
                wr_d[i]  = '0;
                rd_d[i]  = '0;
            end
        end
        if (|grant) begin
            vld_d  = 1'b1;
            tag_od = tag_q[win][rd_q[win]];
            dat_od = data_q[win][rd_q[win]];
            src_d  = win;
            rr_d   = (win == 2'd2) ? 2'd0 : win + 2'd1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk1) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
                wr_q[i]  <= '0;
                rd_q[i]  <= '0;
            end
            rr_q   <= '0;
            vld_q  <= 1'b0;
            tag_oq <= '0;
            dat_oq <= '0;
            src_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            rr_q   <= rr_d;
            vld_q  <= vld_d;
            tag_oq <= tag_od;
            dat_oq <= dat_od;
            src_q  <= src_d;
        end
    end

    // FIFO storage; contents are qualified by the counts.
    always_ff @(posedge clk1) begin
        for (int i = 0; i < 3; i++) begin
            if (push[i] && !rst) begin
                tag_q[i][wr_q[i]]  <= req_tag[i*TW +: TW];
                data_q[i][wr_q[i]] <= req_data[i*DW +: DW];
            end
        end
    end

    assign cdb_valid = vld_q;
    assign cdb_tag   = tag_oq;
    assign cdb_data  = dat_oq;
    assign cdb_src   = src_q;

endmodule
